// File: rtl/johnson_decoder.sv
// ---------------------------------------------------------------------------
// johnson_decoder
//
// Receive-side checker for a Johnson counter stream. Each sample marked by
// in_valid is decoded to its binary index 0..2N-1, illegal codes are flagged,
// and a two-state lock FSM follows the stream. Once LOCKED, any legal code that
// is not the expected successor is reported as a sequence error.
//
// Code convention (counter step q <= {q[N-2:0], ~q[N-1]} starting from 0):
//   k = 0..N      : low k bits 1, rest 0
//   k = N+1..2N-1 : low (k-N) bits 0, rest 1
//
// Handshake: in_valid has no backpressure. q_in is consumed on every rising
// edge where in_valid=1. Every output is registered, so the effect of a sample
// taken at edge t is visible after edge t+1. The outputs idx_valid, illegal and
// seq_err are single-cycle pulses.
//
// Optional feature: define JOHNSON_DEC_STALL_EN to treat a repeated legal code
// (k == previous index) as a hold. In that case idx_valid pulses and nothing
// else changes. When the macro is not defined, a repeat counts as a mismatch.
//
// Ports
//   clk        in   1    rising-edge clock
//   reset      in   1    asynchronous active-low reset
//   in_valid   in   1    q_in is sampled this cycle
//   q_in       in   N    Johnson code from the counter
//   idx        out  IW   decoded index of the last valid legal sample
//   idx_valid  out  1    pulse: idx was updated
//   illegal    out  1    pulse: the sampled code is not a Johnson code
//   seq_err    out  1    pulse: legal code but not the successor (LOCKED only)
//   locked     out  1    FSM is in LOCKED (this is the FSM state bit)
//   err_cnt    out  8    saturating count of illegal + seq_err events
// ---------------------------------------------------------------------------
module johnson_decoder #(
    parameter  int N        = 8,
    parameter  int LOCK_CNT = 4,
    localparam int IW       = $clog2(2*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [N-1:0]  q_in,
    output logic [IW-1:0] idx,
    output logic          idx_valid,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked,
    output logic [7:0]    err_cnt
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [7:0]    LOCK_TARGET = 8'(LOCK_CNT);
    localparam logic [IW-1:0] LAST_IDX    = IW'(2*N-1);

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          idx_valid_q;
    logic          illegal_q;
    logic          seq_err_q;
    logic [7:0]    err_cnt_q;
    logic [7:0]    step_q;
    logic [IW-1:0] prev_q;
    logic          prev_valid_q;

    // Combinational decode of the current sample
    logic [N-1:0]  norm;
    logic [N-1:0]  norm_inc;
    logic          code_legal;
    logic [IW-1:0] ones;
    logic [IW-1:0] code_idx;
    logic [IW-1:0] exp_idx;
    logic          stall_hit;

    always_comb begin
        // Fold the upper half of the cycle onto the lower half. After this,
        // every legal code has the form 0..01..1.
        norm       = q_in[N-1] ? ~q_in : q_in;
        norm_inc   = norm + {{(N-1){1'b0}}, 1'b1};
        // A value of the form 0..01..1 has no bit that survives AND with itself + 1.
        code_legal = ((norm & norm_inc) == '0);

        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + IW'(norm[i]);
        end
        // MSB clear: k = number of ones. MSB set: k = N + number of zeros.
        code_idx = q_in[N-1] ? (IW'(N) + ones) : ones;

        exp_idx = (prev_q == LAST_IDX) ? '0 : (prev_q + IW'(1));

`ifdef JOHNSON_DEC_STALL_EN
        stall_hit = (code_idx == prev_q);
`else
        stall_hit = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= UNLOCKED;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
            seq_err_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
            step_q       <= 8'd0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            if (in_valid) begin
                if (!code_legal) begin
                    // Drop all acquisition progress. The next legal code starts again.
                    illegal_q    <= 1'b1;
                    state_q      <= UNLOCKED;
                    step_q       <= 8'd0;
                    prev_valid_q <= 1'b0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end else begin
                    idx_q       <= code_idx;
                    idx_valid_q <= 1'b1;
                    if (!prev_valid_q) begin
                        // The first legal code after reset or after an illegal code
                        // only anchors the sequence. It does not count as a step.
                        prev_q       <= code_idx;
                        prev_valid_q <= 1'b1;
                    end else if (stall_hit) begin
                        // The counter has not advanced yet. Hold all state.
                        prev_q <= prev_q;
                    end else if (code_idx == exp_idx) begin
                        prev_q <= code_idx;
                        if (state_q == UNLOCKED) begin
                            if (step_q + 8'd1 == LOCK_TARGET) begin
                                state_q <= LOCKED;
                                step_q  <= 8'd0;
                            end else begin
                                step_q <= step_q + 8'd1;
                            end
                        end
                    end else begin
                        // Resynchronise on the code that arrived.
                        prev_q <= code_idx;
                        step_q <= 8'd0;
                        if (state_q == LOCKED) begin
                            seq_err_q <= 1'b1;
                            state_q   <= UNLOCKED;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign locked    = (state_q == LOCKED);
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// ---------------------------------------------------------------------------
// tb_johnson_decoder
//
// Directed bench for johnson_decoder (N=8, LOCK_CNT=4). The reference model
// looks up each sample in a table of the 16 codes that the counter produces.
// It then applies the acquisition and lock rules with plain integers. After
// every clock, all outputs are compared with the model. Literal checks at key
// points pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_johnson_decoder;

    localparam int N        = 8;
    localparam int LOCK_CNT = 4;
    localparam int IW       = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [N-1:0]  q_in;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          illegal;
    logic          seq_err;
    logic          locked;
    logic [7:0]    err_cnt;

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .q_in      (q_in),
        .idx       (idx),
        .idx_valid (idx_valid),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_vec  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    logic [N-1:0] codes [16];
    int m_prev;     // -1: no previous index held
    int m_steps;
    int m_locked;
    int m_err;
    int e_idx, e_idx_valid, e_illegal, e_seq_err;
`ifdef JOHNSON_DEC_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    function automatic int lookup(input logic [N-1:0] c);
        for (int k = 0; k < 16; k++) begin
            if (codes[k] == c) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = -1; m_steps = 0; m_locked = 0; m_err = 0;
        e_idx = 0; e_idx_valid = 0; e_illegal = 0; e_seq_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [N-1:0] c);
        int k;
        e_idx_valid = 0; e_illegal = 0; e_seq_err = 0;
        if (!v) return;
        k = lookup(c);
        if (k < 0) begin
            e_illegal = 1; m_locked = 0; m_steps = 0; m_prev = -1;
            if (m_err < 255) m_err++;
        end else begin
            e_idx = k; e_idx_valid = 1;
            if (m_prev < 0) begin
                m_prev = k;
            end else if (STALL && k == m_prev) begin
                m_prev = k;
            end else if (k == (m_prev + 1) % 16) begin
                m_prev = k;
                if (!m_locked) begin
                    m_steps++;
                    if (m_steps >= LOCK_CNT) begin
                        m_locked = 1; m_steps = 0;
                    end
                end
            end else begin
                if (m_locked) begin
                    e_seq_err = 1;
                    if (m_err < 255) m_err++;
                end
                m_locked = 0; m_steps = 0; m_prev = k;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".idx"},       int'(idx),       e_idx);
        chk({tag, ".idx_valid"}, int'(idx_valid), e_idx_valid);
        chk({tag, ".illegal"},   int'(illegal),   e_illegal);
        chk({tag, ".seq_err"},   int'(seq_err),   e_seq_err);
        chk({tag, ".locked"},    int'(locked),    m_locked);
        chk({tag, ".err_cnt"},   int'(err_cnt),   m_err);
    endtask

    // ---------------- driver ----------------
    task automatic apply(input string tag, input bit v, input logic [N-1:0] c);
        @(negedge clk);
        in_valid = v;
        q_in     = c;
        model_step(v, c);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic apply_list(input string tag, input logic [N-1:0] seq [$]);
        foreach (seq[i]) apply(tag, 1'b1, seq[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] seq [$];

        codes[0] = '0;
        for (int k = 1; k < 16; k++) codes[k] = {codes[k-1][N-2:0], ~codes[k-1][N-1]};

        reset = 1'b0; in_valid = 1'b0; q_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b1;
        apply("idle", 1'b0, 8'h00);

        // Acquisition: 00 anchors the sequence, and four matches lock the FSM.
        seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
        apply_list("acq", seq);
        chk("acq_idx_lit", int'(idx), 4);
        chk("acq_locked_lit", int'(locked), 1);

        // Walk the whole cycle to 80 (idx 15), then wrap to 00.
        seq = '{8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        apply_list("walk", seq);
        chk("idx15_lit", int'(idx), 15);
        apply("idle_mid", 1'b0, 8'h55);
        apply("wrap", 1'b1, 8'h00);
        chk("wrap_idx_lit", int'(idx), 0);
        chk("wrap_seq_err_lit", int'(seq_err), 0);
        chk("wrap_locked_lit", int'(locked), 1);

        // Illegal code while LOCKED
        apply("illegal", 1'b1, 8'h05);
        chk("ill_pulse_lit", int'(illegal), 1);
        chk("ill_locked_lit", int'(locked), 0);
        chk("ill_err_lit", int'(err_cnt), 1);
        chk("ill_idx_lit", int'(idx), 0);

        // Relock ending at 07, then skip to 3F (k=6)
        seq = '{8'hC0, 8'h80, 8'h00, 8'h01, 8'h03, 8'h07};
        apply_list("relock1", seq);
        chk("relock1_locked_lit", int'(locked), 1);
        apply("skip", 1'b1, 8'h3F);
        chk("skip_seq_err_lit", int'(seq_err), 1);
        chk("skip_locked_lit", int'(locked), 0);
        chk("skip_idx_lit", int'(idx), 6);
        chk("skip_err_lit", int'(err_cnt), 2);

        // Relock ending at 07, then repeat 07
        seq = '{8'h80, 8'h00, 8'h01, 8'h03, 8'h07};
        apply_list("relock2", seq);
        chk("relock2_locked_lit", int'(locked), 1);
        apply("repeat", 1'b1, 8'h07);
`ifdef JOHNSON_DEC_STALL_EN
        chk("rep_seq_err_lit", int'(seq_err), 0);
        chk("rep_locked_lit", int'(locked), 1);
        chk("rep_idx_valid_lit", int'(idx_valid), 1);
`else
        chk("rep_seq_err_lit", int'(seq_err), 1);
        chk("rep_locked_lit", int'(locked), 0);
        chk("rep_err_lit", int'(err_cnt), 3);
`endif

        // Relock, then assert reset mid-stream
        seq = '{8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        apply_list("relock3", seq);
        chk("relock3_locked_lit", int'(locked), 1);
        @(negedge clk);
        in_valid = 1'b1; q_in = 8'hFE;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        chk("rst_locked_lit", int'(locked), 0);
        chk("rst_err_lit", int'(err_cnt), 0);
        chk("rst_idx_lit", int'(idx), 0);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;

        // Saturation: 256 illegal samples, plus one more
        for (int i = 0; i < 256; i++) begin
            apply("sat", 1'b1, (i % 2) ? 8'hA5 : 8'h05);
        end
        chk("sat_err_lit", int'(err_cnt), 255);
        apply("sat_hold", 1'b1, 8'h02);
        chk("sat_hold_lit", int'(err_cnt), 255);

        // Recover after the illegal codes: the first legal code only anchors the sequence.
        apply("recover_anchor", 1'b1, 8'hF0);
        chk("recover_idx_lit", int'(idx), 12);
        chk("recover_locked_lit", int'(locked), 0);
        apply("tail_idle", 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
